// File: rtl/mux2x1_arb.sv
// mux2x1_arb: two-requester arbiter and sequencer for a 2:1 mux datapath.
// Grants one requester at a time, drives the mux select from that grant, and
// forwards the selected data downstream with a valid/ready handshake. Each
// grant is limited to BURST transfers, after which arbitration runs again.
// Optional feature macro: MUX2X1_ARB_FIXED_PRI_EN selects fixed priority
// (requester 0 always wins contention). When it is undefined, contention is
// resolved round-robin.
module mux2x1_arb #(
  parameter int WIDTH = 1,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] i0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] i1,
  output logic             gnt1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam logic [7:0] CNT_LAST = 8'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       own_valid;
  logic       xfer;
  logic       own_req;
  logic       burst_done;
  logic       arb_point;
  logic       arb_any;
  logic       arb_idx;

  // Datapath and handshake; outputs are forced quiet while reset is held
  always_comb begin
    own_valid = (gnt0 & req0) | (gnt1 & req1);
    y_valid   = own_valid & ~rst;
    y         = (s & ~rst) ? i1 : i0;
    xfer      = own_valid & y_ready;
  end

  // Detect release events: withdrawn request or last transfer of the burst
  always_comb begin
    case (state)
      G0:      own_req = req0;
      G1:      own_req = req1;
      default: own_req = 1'b0;
    endcase
    burst_done = xfer & (cnt == CNT_LAST);
    arb_point  = (state == IDLE) | ~own_req | burst_done;
  end

`ifdef MUX2X1_ARB_FIXED_PRI_EN
  // Fixed priority: requester 0 wins whenever it is requesting
  always_comb begin
    arb_any = req0 | req1;
    arb_idx = ~req0;
  end
`else
  logic last;

  // Round-robin: on contention the requester that was not granted last wins
  always_comb begin
    arb_any = req0 | req1;
    if (req0 & req1) begin
      arb_idx = ~last;
    end else begin
      arb_idx = ~req0;
    end
  end

  // Remember the index of every new grant, including re-grants to the same side
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (arb_point & arb_any) begin
      last <= arb_idx;
    end
  end
`endif

  // Grant state machine with registered grant, select and burst counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      s     <= 1'b0;
      cnt   <= 8'd0;
    end else if (arb_point) begin
      cnt <= 8'd0;
      if (!arb_any) begin
        state <= IDLE;
        gnt0  <= 1'b0;
        gnt1  <= 1'b0;
        s     <= 1'b0;
      end else if (arb_idx) begin
        state <= G1;
        gnt0  <= 1'b0;
        gnt1  <= 1'b1;
        s     <= 1'b1;
      end else begin
        state <= G0;
        gnt0  <= 1'b1;
        gnt1  <= 1'b0;
        s     <= 1'b0;
      end
    end else if (xfer) begin
      cnt <= cnt + 8'd1;
    end
  end

  // The two grants are mutually exclusive and the select always follows gnt1
  a_gnt_excl: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  a_sel_gnt:  assert property (@(posedge clk) disable iff (rst) (s == gnt1));

endmodule

// File: tb/tb_mux2x1_arb.sv
// tb_mux2x1_arb: directed bench for mux2x1_arb. Two instances (BURST=4 and
// BURST=2) share all inputs; a behavioural model tracks the owner and the
// transfers used in each grant and is compared with both every cycle.
module tb_mux2x1_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0;
  logic         req1;
  logic         y_ready;
  logic [W-1:0] i0;
  logic [W-1:0] i1;

  logic [1:0]   gnt0_d;
  logic [1:0]   gnt1_d;
  logic [1:0]   s_d;
  logic [1:0]   yv_d;
  logic [W-1:0] y_d [2];

  int checks   = 0;
  int failures = 0;

  // Model state: owner -1 idle / 0 / 1, transfers used in the grant, last winner
  int owner  [2];
  int used   [2];
  int last_m [2];
  int burst_m [2] = '{4, 2};
  bit started = 1'b0;

  logic         exp_g0;
  logic         exp_g1;
  logic         exp_v;
  logic [W-1:0] exp_y;

  logic [7:0] rec_g0a;
  logic [7:0] rec_g1a;
  logic [7:0] rec_g1b;
  logic [7:0] rec_sb;
  logic [3:0] vec_tbl [12];

  mux2x1_arb #(.WIDTH(W), .BURST(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0(req0), .i0(i0), .gnt0(gnt0_d[0]),
    .req1(req1), .i1(i1), .gnt1(gnt1_d[0]),
    .s(s_d[0]), .y(y_d[0]), .y_valid(yv_d[0]), .y_ready(y_ready)
  );

  mux2x1_arb #(.WIDTH(W), .BURST(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req0(req0), .i0(i0), .gnt0(gnt0_d[1]),
    .req1(req1), .i1(i1), .gnt1(gnt1_d[1]),
    .s(s_d[1]), .y(y_d[1]), .y_valid(yv_d[1]), .y_ready(y_ready)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge
  task automatic apply_stimulus(input logic r, input logic q0, input logic q1,
                                input logic rdy, input logic [W-1:0] d0,
                                input logic [W-1:0] d1);
    @(posedge clk);
    #2;
    rst     = r;
    req0    = q0;
    req1    = q1;
    y_ready = rdy;
    i0      = d0;
    i1      = d1;
  endtask

  // Who wins arbitration given the current requests and the previous winner
  function automatic int pick(input int lst);
    if (req0 && req1) begin
`ifdef MUX2X1_ARB_FIXED_PRI_EN
      return 0;
`else
      return 1 - lst;
`endif
    end else if (req0) begin
      return 0;
    end else if (req1) begin
      return 1;
    end
    return -1;
  endfunction

  // Reference model advanced on every rising edge
  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      for (int k = 0; k < 2; k++) begin
        owner[k]  = -1;
        used[k]   = 0;
        last_m[k] = 1;
      end
    end else if (started) begin
      for (int k = 0; k < 2; k++) begin
        logic mine;
        logic moved;
        mine  = (owner[k] == 0) ? req0 : ((owner[k] == 1) ? req1 : 1'b0);
        moved = mine && y_ready;
        if (owner[k] < 0 || !mine || (moved && used[k] == burst_m[k] - 1)) begin
          owner[k] = pick(last_m[k]);
          used[k]  = 0;
          if (owner[k] >= 0) last_m[k] = owner[k];
        end else if (moved) begin
          used[k] = used[k] + 1;
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        exp_g0 = (owner[k] == 0);
        exp_g1 = (owner[k] == 1);
        exp_v  = !rst && ((exp_g0 && req0) || (exp_g1 && req1));
        exp_y  = (!rst && exp_g1) ? i1 : i0;
        check_bit($sformatf("b%0d.gnt0", burst_m[k]), gnt0_d[k], exp_g0);
        check_bit($sformatf("b%0d.gnt1", burst_m[k]), gnt1_d[k], exp_g1);
        check_bit($sformatf("b%0d.s", burst_m[k]), s_d[k], exp_g1);
        check_bit($sformatf("b%0d.y_valid", burst_m[k]), yv_d[k], exp_v);
        check_word($sformatf("b%0d.y", burst_m[k]), y_d[k], exp_y);
      end
    end
  end

  // Directed scenario sequence with hand-computed literal expectations
  initial begin
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; y_ready = 1'b1;
    i0 = 8'hA5; i1 = 8'h3C;

    // Reset held two cycles with both requesting
    apply_stimulus(1, 1, 1, 1, 8'hA5, 8'h3C);
    apply_stimulus(1, 1, 1, 1, 8'hA5, 8'h3C);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_bit("rst.gnt0", gnt0_d[k], 1'b0);
      check_bit("rst.gnt1", gnt1_d[k], 1'b0);
      check_bit("rst.s", s_d[k], 1'b0);
      check_bit("rst.y_valid", yv_d[k], 1'b0);
      check_word("rst.y", y_d[k], 8'hA5);
    end

    // Release reset and record grant pattern under contention
    apply_stimulus(0, 1, 1, 1, 8'hA5, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      rec_g0a[i] = gnt0_d[0];
      rec_g1a[i] = gnt1_d[0];
      rec_g1b[i] = gnt1_d[1];
      rec_sb[i]  = s_d[1];
    end
    check_bit("first_grant", rec_g0a[0], 1'b1);
`ifdef MUX2X1_ARB_FIXED_PRI_EN
    check_word("fixed.b4.gnt0", rec_g0a, 8'hFF);
    check_word("fixed.b4.gnt1", rec_g1a, 8'h00);
    check_word("fixed.b2.gnt1", rec_g1b, 8'h00);
    check_word("fixed.b2.s", rec_sb, 8'h00);
`else
    check_word("rr.b4.gnt0", rec_g0a, 8'h0F);
    check_word("rr.b4.gnt1", rec_g1a, 8'hF0);
    check_word("rr.b2.gnt1", rec_g1b, 8'hCC);
    check_word("rr.b2.s", rec_sb, 8'hCC);
`endif

    // Single requester 0 streaming through several bursts
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 1, 0, 1, 8'(i * 7 + 1), 8'h00);
    end
    @(negedge clk);
    check_bit("single.b4.gnt0", gnt0_d[0], 1'b1);
    check_bit("single.b4.y_valid", yv_d[0], 1'b1);
    check_word("single.b4.y", y_d[0], 8'h40);

    // Backpressure while requester 1 owns the mux
    apply_stimulus(0, 0, 1, 1, 8'h11, 8'h80);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 0, 1, 0, 8'h11, 8'(64 + i));
    end
    @(negedge clk);
    check_bit("bp.b4.gnt1", gnt1_d[0], 1'b1);
    check_bit("bp.b2.gnt1", gnt1_d[1], 1'b1);
    check_word("bp.b2.y", y_d[1], 8'h44);
    check_bit("bp.b2.y_valid", yv_d[1], 1'b1);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 0, 1, 1, 8'h11, 8'(144 + i));
    end

    // Withdraw requester 0 after one transfer while requester 1 waits
    apply_stimulus(0, 1, 0, 1, 8'h21, 8'h99);
    apply_stimulus(0, 1, 0, 1, 8'h21, 8'h99);
    apply_stimulus(0, 0, 1, 1, 8'h22, 8'h9A);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_bit("wd.gnt1", gnt1_d[k], 1'b1);
      check_bit("wd.s", s_d[k], 1'b1);
      check_bit("wd.gnt0", gnt0_d[k], 1'b0);
    end

    // Withdraw requester 0 with nobody else waiting
    apply_stimulus(0, 1, 0, 1, 8'h23, 8'h9B);
    apply_stimulus(0, 1, 0, 1, 8'h23, 8'h9B);
    apply_stimulus(0, 0, 0, 1, 8'h24, 8'h9C);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_bit("idle.gnt0", gnt0_d[k], 1'b0);
      check_bit("idle.gnt1", gnt1_d[k], 1'b0);
    end

    // Directed mixed vectors {rst, req0, req1, y_ready}
    vec_tbl = '{4'h7, 4'h7, 4'h6, 4'h6, 4'h3, 4'h7, 4'h4, 4'h5, 4'h1, 4'hF, 4'h7, 4'h3};
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vec_tbl[i][3], vec_tbl[i][2], vec_tbl[i][1], vec_tbl[i][0],
                     8'(16 * i + 3), 8'(255 - i));
    end

    // Reset asserted in the middle of a burst
    apply_stimulus(0, 1, 1, 1, 8'h5A, 8'hC3);
    apply_stimulus(0, 1, 1, 1, 8'h5A, 8'hC3);
    apply_stimulus(0, 1, 1, 1, 8'h5A, 8'hC3);
    apply_stimulus(1, 1, 1, 1, 8'h5A, 8'hC3);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_bit("midrst.y_valid", yv_d[k], 1'b0);
      check_word("midrst.y", y_d[k], 8'h5A);
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_bit("midrst.gnt0", gnt0_d[k], 1'b0);
      check_bit("midrst.gnt1", gnt1_d[k], 1'b0);
    end
    apply_stimulus(0, 1, 1, 1, 8'h5A, 8'hC3);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_bit("postrst.gnt0", gnt0_d[k], 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 1, 1, 1, 8'(90 + i), 8'(200 + i));
    end
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 0, 8'h00, 8'h00);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
